mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data RAM between the core load/store path (requester 0) and an external loader/DMA port (requester 1). It sits between the core's ALU-address/store-data path and the RAM. It grants one access per cycle, drives the RAM port, returns read data with a one-cycle-delayed valid, and stalls the core while it waits. Starvation is bounded by a per-owner burst limit.

## Interface
- DW, 32, data width (matches `MXLEN)
- AW, 32, address width
- MAX_BURST, 4, max consecutive contended grants to one owner before switching (≥1)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- req0  in  1  core access request, held with payload until gnt0
- we0  in  1  core write enable (0 = read)
- addr0  in  AW  core byte address
- wdata0  in  DW  core write data
- wstrb0  in  DW/8  core byte strobes
- gnt0  out  1  core access issued this cycle
- rvalid0  out  1  core read data valid on rdata0
- rdata0  out  DW  core read data
- core_stall  out  1  req0 & ~gnt0
- req1, we1, addr1, wdata1, wstrb1, gnt1, rvalid1, rdata1: same as requester 0, loader side
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_wstrb  out  DW/8  RAM byte strobes
- mem_rdata  in  DW  RAM read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE (no grant last cycle), OWN0, OWN1 (owner of last granted access). Register cnt, width clog2(MAX_BURST)+1.
- Grant decision is combinational from state, cnt, req0, req1; at most one of gnt0/gnt1 high.
- Neither req: no grant, next state IDLE, cnt ← 0.
- Only reqN: gnt N, next state OWNN, cnt ← 0.
- Both req, state IDLE: gnt0, next OWN0, cnt ← 1 (core wins ties).
- Both req, state OWNN, cnt < MAX_BURST: gnt N, cnt ← cnt+1.
- Both req, state OWNN, cnt == MAX_BURST: gnt other, next OWN(other), cnt ← 1.
- On gnt N: mem_en=1, mem_we/addr/wdata/wstrb = requester N's inputs. No grant: mem_en=0, mem_we=0, mem_addr/wdata/wstrb = 0.
- Read tag: registered rsel[1:0] ← {gnt1 & ~we1, gnt0 & ~we0}; rvalidN = rsel[N]. Writes produce no rvalid.
- rdata0 = rdata1 = mem_rdata (pass-through); valid only when the matching rvalid is high.
- Requester must keep req and payload stable until gnt; dropping req before gnt is legal (request withdrawn, no access).

## Timing
- Grant latency: 0 cycles uncontended (gnt same cycle as req), at most MAX_BURST cycles contended.
- Read data: rvalidN and mem_rdata one cycle after gntN with weN=0. Write completes at the gnt edge.
- Back-to-back grants allowed every cycle; read in cycle t and access by other requester in t+1 both proceed (rvalid for t and gnt for t+1 coincide).
- Reset (asynchronous, any cycle): state IDLE, cnt 0, rsel 0 → rvalid0=rvalid1=0 immediately; gnt0/gnt1/mem_en follow the combinational rule from IDLE (so a req held during reset is granted in the first cycle after release, not during RST). During RST all gnt, mem_en, mem_we forced 0 and core_stall = req0. A read in flight at reset assertion is dropped (no rvalid).
- cnt saturates at MAX_BURST; never wraps.

## Test plan
- Reset: assert RST mid-read (gnt0 read at t, RST at t+½) → rvalid0=0 at t+1, state IDLE, cnt 0; after release, held req0 granted first cycle.
- Single core read: req0=1, we0=0, addr0=0x10, RAM holds 0xDEADBEEF → gnt0 same cycle, mem_addr=0x10, rvalid0=1 and rdata0=0xDEADBEEF next cycle, core_stall=0.
- Contention, MAX_BURST=4: req0 and req1 held high from IDLE → grant sequence 0,0,0,0,1,1,1,1,0; core_stall=1 exactly in the cycles granted to 1.
- Tie from IDLE: req0 and req1 rise together → gnt0=1, gnt1=0, core_stall=0, loader waits.
- Write then read, cross-requester: gnt1 write 0x12345678 strobe 0xF to 0x20 at t, gnt0 read 0x20 at t+1 → rvalid0 at t+2 with 0x12345678; rvalid1 never asserted.
- Burst-count reset: req1 alone for 6 cycles then req0 joins → cnt was 0, loader keeps 4 more contended grants, then core granted.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port, synchronous-read data RAM between the
//            core load/store path (requester 0) and the loader/DMA port
//            (requester 1). One access is granted per cycle. Read data
//            returns one cycle later with a per-requester valid. Under
//            contention, each owner keeps at most MAX_BURST consecutive
//            grants before the other requester is served.
// Ports    : CLK, RST            clock / asynchronous active-high reset
//            req/we/addr/wdata/wstrb{0,1}   requester payloads (in)
//            gnt{0,1}            access issued this cycle (out)
//            rvalid{0,1}, rdata{0,1}        read return (out)
//            core_stall          core request waiting (out)
//            mem_en/we/addr/wdata/wstrb     RAM port (out)
//            mem_rdata           RAM read data, valid a cycle after a read
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic            CLK,
  input  logic            RST,
  // requester 0 : core
  input  logic            req0,
  input  logic            we0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW/8-1:0] wstrb0,
  output logic            gnt0,
  output logic            rvalid0,
  output logic [DW-1:0]   rdata0,
  output logic            core_stall,
  // requester 1 : loader
  input  logic            req1,
  input  logic            we1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata1,
  input  logic [DW/8-1:0] wstrb1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata1,
  // RAM port
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] c_burst_max = CW'(MAX_BURST);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);

  // state = owner of the last granted access (IDLE when nothing was granted)
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_own0 = 2'd1;
  localparam logic [1:0] c_own1 = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_arb;    // raw arbitration result, one-hot {gnt1, gnt0}
  logic [1:0]    w_grant;  // arbitration result with reset masking applied
  logic [1:0]    r_rsel;   // which requester owns the read data returning now

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_rsel  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rsel  <= {w_grant[1] & ~we1, w_grant[0] & ~we0};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and grant decision
  // cnt counts consecutive contended grants to the current owner; a solo
  // grant leaves it at 0, so a newly contending requester still waits a
  // full MAX_BURST grants. cnt stops at MAX_BURST because the owner changes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_arb       = 2'b00;
    w_state_nxt = c_idle;
    w_cnt_nxt   = '0;
    if (req0 && req1) begin
      case (r_state)
        c_own0: begin
          if (r_cnt < c_burst_max) begin
            w_arb       = 2'b01;
            w_state_nxt = c_own0;
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end else begin
            w_arb       = 2'b10;
            w_state_nxt = c_own1;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        c_own1: begin
          if (r_cnt < c_burst_max) begin
            w_arb       = 2'b10;
            w_state_nxt = c_own1;
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end else begin
            w_arb       = 2'b01;
            w_state_nxt = c_own0;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        default: begin
          // tie from idle: the core wins
          w_arb       = 2'b01;
          w_state_nxt = c_own0;
          w_cnt_nxt   = c_cnt_one;
        end
      endcase
    end else if (req0) begin
      w_arb       = 2'b01;
      w_state_nxt = c_own0;
    end else if (req1) begin
      w_arb       = 2'b10;
      w_state_nxt = c_own1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: grants are suppressed while RST is high so that nothing reaches
  // the RAM during reset; a held request is served right after release.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant    = RST ? 2'b00 : w_arb;
    gnt0       = w_grant[0];
    gnt1       = w_grant[1];
    core_stall = req0 & ~w_grant[0];
    mem_en     = |w_grant;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    case (w_grant)
      2'b01: begin
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_wstrb = wstrb0;
      end
      2'b10: begin
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_wstrb = wstrb1;
      end
      default: begin
        mem_we    = 1'b0;
      end
    endcase
    rvalid0 = r_rsel[0];
    rvalid1 = r_rsel[1];
    rdata0  = mem_rdata;
    rdata1  = mem_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A small byte-strobed RAM
//            answers the DUT's memory port; a behavioural model (owner and
//            run length as plain integers, a shadow copy of memory) predicts
//            every output each cycle. Directed scenarios add literal checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            req0 = 1'b0, we0 = 1'b0;
  logic [AW-1:0]   addr0 = '0;
  logic [DW-1:0]   wdata0 = '0;
  logic [DW/8-1:0] wstrb0 = '0;
  logic            req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]   addr1 = '0;
  logic [DW-1:0]   wdata1 = '0;
  logic [DW/8-1:0] wstrb1 = '0;
  logic            gnt0, gnt1, rvalid0, rvalid1, core_stall;
  logic [DW-1:0]   rdata0, rdata1;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata = '0;

  int checks = 0;
  int errs   = 0;

  mem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .wstrb0(wstrb0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .core_stall(core_stall),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // RAM: 16 words, synchronous read, byte-strobed write
  // --------------------------------------------------------------------------
  logic [DW-1:0] ram [16] = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                              32'hDEAD_BEEF, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777,
                              32'h8888_8888, 32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB,
                              32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 32'hFFFF_FFFF};
  logic [DW-1:0] shadow [16] = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                 32'hDEAD_BEEF, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777,
                                 32'h8888_8888, 32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB,
                                 32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 32'hFFFF_FFFF};

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < DW/8; b++)
          if (mem_wstrb[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[5:2]];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural model + per-cycle compare (outputs sampled on falling edge)
  // owner: -1 none, 0/1 last granted requester; run: consecutive grants the
  // owner received while the other requester was also asking.
  // --------------------------------------------------------------------------
  int            owner = -1;
  int            run   = 0;
  bit            pend0 = 1'b0, pend1 = 1'b0;
  logic [DW-1:0] pdat  = '0;

  always @(negedge CLK) begin : model
    int              win;
    logic            e_we;
    logic [AW-1:0]   e_a;
    logic [DW-1:0]   e_d;
    logic [DW/8-1:0] e_s;
    if (RST) begin
      chk("m_rst_gnt",    64'({gnt1, gnt0}), 64'(0));
      chk("m_rst_en",     64'(mem_en), 64'(0));
      chk("m_rst_we",     64'(mem_we), 64'(0));
      chk("m_rst_rvalid", 64'({rvalid1, rvalid0}), 64'(0));
      chk("m_rst_stall",  64'(core_stall), 64'(req0));
      owner = -1; run = 0; pend0 = 1'b0; pend1 = 1'b0;
    end else begin
      chk("m_rvalid0", 64'(rvalid0), 64'(pend0));
      chk("m_rvalid1", 64'(rvalid1), 64'(pend1));
      if (pend0) chk("m_rdata0", 64'(rdata0), 64'(pdat));
      if (pend1) chk("m_rdata1", 64'(rdata1), 64'(pdat));
      if (req0 && req1) begin
        if (owner < 0)      win = 0;
        else if (run < MB)  win = owner;
        else                win = 1 - owner;
        run = (win == owner) ? run + 1 : 1;
      end else begin
        win = req0 ? 0 : (req1 ? 1 : -1);
        run = 0;
      end
      owner = win;
      e_we = 1'b0; e_a = '0; e_d = '0; e_s = '0;
      if (win == 0) begin
        e_we = we0; e_a = addr0; e_d = wdata0; e_s = wstrb0;
      end else if (win == 1) begin
        e_we = we1; e_a = addr1; e_d = wdata1; e_s = wstrb1;
      end
      chk("m_gnt0",  64'(gnt0),   64'(win == 0));
      chk("m_gnt1",  64'(gnt1),   64'(win == 1));
      chk("m_en",    64'(mem_en), 64'(win >= 0));
      chk("m_we",    64'(mem_we), 64'(e_we));
      chk("m_addr",  64'(mem_addr),  64'(e_a));
      chk("m_wdata", 64'(mem_wdata), 64'(e_d));
      chk("m_wstrb", 64'(mem_wstrb), 64'(e_s));
      chk("m_stall", 64'(core_stall), 64'(req0 && win != 0));
      pend0 = (win == 0) && !we0;
      pend1 = (win == 1) && !we1;
      if (win >= 0) begin
        if (!e_we) pdat = shadow[e_a[5:2]];
        else
          for (int b = 0; b < DW/8; b++)
            if (e_s[b]) shadow[e_a[5:2]][8*b +: 8] = e_d[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; wstrb0 = s;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; wstrb1 = s;
  endtask

  task automatic next_drive();
    @(posedge CLK); #1;
  endtask

  int seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    logic g0, g1;
    int   p;
    // reset with a held core read
    drive0(1'b1, 1'b0, 32'h10, '0, '0);
    repeat (2) @(negedge CLK);
    chk("rst_gnt0",    64'(gnt0), 64'(0));
    chk("rst_stall",   64'(core_stall), 64'(1));
    chk("rst_mem_en",  64'(mem_en), 64'(0));
    chk("rst_rvalid0", 64'(rvalid0), 64'(0));
    next_drive(); RST = 1'b0;
    // single core read, granted in first cycle after release
    @(negedge CLK);
    chk("single_gnt0",  64'(gnt0), 64'(1));
    chk("single_addr",  64'(mem_addr), 64'h10);
    chk("single_stall", 64'(core_stall), 64'(0));
    next_drive(); drive0(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    chk("single_rvalid0", 64'(rvalid0), 64'(1));
    chk("single_rdata0",  64'(rdata0), 64'hDEADBEEF);

    // tie from idle, then contention sequence
    next_drive();
    drive0(1'b1, 1'b0, 32'h04, '0, '0);
    drive1(1'b1, 1'b0, 32'h08, '0, '0);
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      chk("contend_gnt0",  64'(gnt0), 64'(seq[i] == 0));
      chk("contend_gnt1",  64'(gnt1), 64'(seq[i] == 1));
      chk("contend_stall", 64'(core_stall), 64'(seq[i] == 1));
    end
    next_drive(); drive0(1'b0, 1'b0, '0, '0, '0); drive1(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);

    // loader write then core read of the same word
    next_drive(); drive1(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    @(negedge CLK);
    chk("xw_gnt1",  64'(gnt1), 64'(1));
    chk("xw_we",    64'(mem_we), 64'(1));
    chk("xw_wdata", 64'(mem_wdata), 64'h12345678);
    next_drive(); drive1(1'b0, 1'b0, '0, '0, '0); drive0(1'b1, 1'b0, 32'h20, '0, '0);
    @(negedge CLK);
    chk("xr_gnt0",   64'(gnt0), 64'(1));
    chk("xr_rvalid1", 64'(rvalid1), 64'(0));
    next_drive(); drive0(1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    chk("xr_rvalid0", 64'(rvalid0), 64'(1));
    chk("xr_rdata0",  64'(rdata0), 64'h12345678);
    chk("xr_rvalid1b", 64'(rvalid1), 64'(0));

    // loader alone for 6 cycles, then core joins: 4 more loader grants
    next_drive(); drive1(1'b1, 1'b0, 32'h30, '0, '0);
    repeat (6) begin
      @(negedge CLK);
      chk("solo_gnt1", 64'(gnt1), 64'(1));
    end
    next_drive(); drive0(1'b1, 1'b0, 32'h34, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("burst_gnt1", 64'(gnt1), 64'(i < 4));
      chk("burst_gnt0", 64'(gnt0), 64'(i == 4));
    end
    next_drive(); drive0(1'b0, 1'b0, '0, '0, '0); drive1(1'b0, 1'b0, '0, '0, '0);

    // reset in the middle of a read
    next_drive(); drive0(1'b1, 1'b0, 32'h10, '0, '0);
    @(negedge CLK);
    chk("mid_gnt0", 64'(gnt0), 64'(1));
    #2 RST = 1'b1;
    @(negedge CLK);
    chk("mid_rvalid0", 64'(rvalid0), 64'(0));
    chk("mid_gnt0_rst", 64'(gnt0), 64'(0));
    chk("mid_stall", 64'(core_stall), 64'(1));
    next_drive(); RST = 1'b0;
    @(negedge CLK);
    chk("rel_gnt0", 64'(gnt0), 64'(1));
    next_drive();
    chk("rel_rvalid0", 64'(rvalid0), 64'(1));
    RST = 1'b1;
    #1 chk("async_rvalid0", 64'(rvalid0), 64'(0));
    next_drive(); RST = 1'b0; drive0(1'b0, 1'b0, '0, '0, '0);

    // randomized traffic, with occasional withdrawal and reset
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      g0 = gnt0; g1 = gnt1;
      next_drive();
      p = (c < 2000) ? 50 : 90;
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 499) == 0) RST = 1'b1;
      if (!req0 || g0)
        drive0($urandom_range(0, 99) < p, 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)));
      else if ($urandom_range(0, 31) == 0) req0 = 1'b0;
      if (!req1 || g1)
        drive1($urandom_range(0, 99) < p, 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)));
      else if ($urandom_range(0, 31) == 0) req1 = 1'b0;
    end
    drive0(1'b0, 1'b0, '0, '0, '0); drive1(1'b0, 1'b0, '0, '0, '0); RST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
